led_blink_ctrl: RTL and testbench

LED_BLINK_CTRL -- requirements
Module: led_blink

---
 rtl/led_blink_ctrl.sv | 158 +++++++++++++++
 tb/tb_led_blink_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/led_blink_ctrl.sv
// LED blink and LED-matrix row scanner.
// A free-running blink counter toggles led_fpga. A four-state serial engine
// shifts one 8-bit row pattern MSB first into an external 74HC595-style
// register, pulses the storage latch, updates the row select and holds the
// row before moving on to the next one. Every output comes straight from a
// flop. The flop values are computed from the next state, so the outputs
// stay aligned with the state that is currently active.
module led_blink_ctrl #(
    parameter int CNT_MAX  = 25_000_000,
    parameter int SCK_DIV  = 4,
    parameter int ROW_HOLD = 1000
) (
    input  logic       clk,
    input  logic       reset_n,   // active-high synchronous reset, despite the name
    output logic       led_fpga,
    output logic [2:0] ledm_sel,
    output logic       sp_clk,
    output logic       sp_dat,
    output logic       sp_ratch
);

    localparam int PH_MAX = (SCK_DIV > ROW_HOLD) ? SCK_DIV : ROW_HOLD;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int CNT_W  = $clog2(CNT_MAX + 1);

    localparam logic [PH_W-1:0]  SCK_LAST   = PH_W'(SCK_DIV - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(ROW_HOLD - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              half_q, half_d;        // 0: sp_clk low phase, 1: high phase
    logic [7:0]        shreg_q, shreg_d;
    logic [2:0]        row_q, row_d;
    logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              led_q, led_d;
    logic [2:0]        ledm_sel_q, ledm_sel_d;
    logic              sp_clk_q, sp_clk_d;
    logic              sp_dat_q, sp_dat_d;
    logic              sp_ratch_q, sp_ratch_d;

    // Blink counter: wrap at CNT_MAX-1 and toggle the LED on the same edge
    always_comb begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
        led_d       = led_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            led_d       = ~led_q;
        end
    end

    // Serial engine next state; the row pattern is sampled only in IDLE,
    // so a blink toggle mid-frame waits for the next row
    always_comb begin
        state_d   = state_q;
        ph_cnt_d  = ph_cnt_q + PH_W'(1);
        bit_cnt_d = bit_cnt_q;
        half_d    = half_q;
        shreg_d   = shreg_q;
        row_d     = row_q;
        case (state_q)
            ST_IDLE: begin
                shreg_d   = led_q ? (8'h80 >> row_q) : 8'h00;
                bit_cnt_d = 3'd7;
                half_d    = 1'b0;
                ph_cnt_d  = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ph_cnt_q == SCK_LAST) begin
                    ph_cnt_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (bit_cnt_q == 3'd0) begin
                            state_d = ST_LATCH;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                            shreg_d   = {shreg_q[6:0], 1'b0};
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (ph_cnt_q == SCK_LAST) begin
                    ph_cnt_d = '0;
                    state_d  = ST_HOLD;
                end
            end
            default: begin // ST_HOLD
                if (ph_cnt_q == HOLD_LAST) begin
                    ph_cnt_d = '0;
                    row_d    = row_q + 3'd1;
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    // Output values derived from the state being entered, so the registered
    // outputs line up with it; data only moves at a bit boundary (clock low)
    always_comb begin
        sp_clk_d   = (state_d == ST_SHIFT) && half_d;
        sp_dat_d   = (state_d == ST_SHIFT) && shreg_d[7];
        sp_ratch_d = (state_d == ST_LATCH);
        ledm_sel_d = ledm_sel_q;
        if (state_q == ST_SHIFT && state_d == ST_LATCH) begin
            ledm_sel_d = row_q;
        end
    end

    // State and output registers; reset aborts any transfer on the next edge
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q     <= ST_IDLE;
            ph_cnt_q    <= '0;
            bit_cnt_q   <= 3'd0;
            half_q      <= 1'b0;
            shreg_q     <= 8'h00;
            row_q       <= 3'd0;
            blink_cnt_q <= '0;
            led_q       <= 1'b0;
            ledm_sel_q  <= 3'd0;
            sp_clk_q    <= 1'b0;
            sp_dat_q    <= 1'b0;
            sp_ratch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_cnt_q    <= ph_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            half_q      <= half_d;
            shreg_q     <= shreg_d;
            row_q       <= row_d;
            blink_cnt_q <= blink_cnt_d;
            led_q       <= led_d;
            ledm_sel_q  <= ledm_sel_d;
            sp_clk_q    <= sp_clk_d;
            sp_dat_q    <= sp_dat_d;
            sp_ratch_q  <= sp_ratch_d;
        end
    end

    assign led_fpga = led_q;
    assign ledm_sel = ledm_sel_q;
    assign sp_clk   = sp_clk_q;
    assign sp_dat   = sp_dat_q;
    assign sp_ratch = sp_ratch_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl: random run/reset episodes compared cycle by cycle
// against a time-based model, plus per-latch checks of the shifted byte.
module tb_led_blink_ctrl;

    localparam int CM = 10;
    localparam int S  = 2;
    localparam int RH = 4;
    localparam int F  = 1 + 17 * S + RH;   // cycles per row

    logic       clk;
    logic       reset_n;
    logic       led_fpga;
    logic [2:0] ledm_sel;
    logic       sp_clk;
    logic       sp_dat;
    logic       sp_ratch;

    int checks = 0;
    int errors = 0;

    led_blink_ctrl #(
        .CNT_MAX (CM),
        .SCK_DIV (S),
        .ROW_HOLD(RH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .led_fpga(led_fpga),
        .ledm_sel(ledm_sel),
        .sp_clk  (sp_clk),
        .sp_dat  (sp_dat),
        .sp_ratch(sp_ratch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Byte shown for row frame k: LED state at the frame start picks the
    // single lit column (row 0 -> bit 7) or a blank row.
    function automatic int row_byte(input int k);
        int led_at_start;
        led_at_start = ((k * F) / CM) % 2;
        return led_at_start ? (1 << (7 - (k % 8))) : 0;
    endfunction

    // Expected outputs t edges after reset release
    task automatic model(input int t, output int e_led, output int e_sel,
                         output int e_sck, output int e_dat, output int e_lat);
        int k, p, q, b, prev_row;
        k = t / F;
        p = t % F;
        prev_row = (k == 0) ? 0 : (k - 1) % 8;
        e_led = (t / CM) % 2;
        e_sck = 0;
        e_dat = 0;
        e_lat = 0;
        e_sel = k % 8;
        if (p == 0) begin
            e_sel = prev_row;
        end else if (p <= 16 * S) begin
            q = p - 1;
            b = q / (2 * S);
            e_sck = ((q % (2 * S)) >= S) ? 1 : 0;
            e_dat = (row_byte(k) >> (7 - b)) & 1;
            e_sel = prev_row;
        end else if (p <= 17 * S) begin
            e_lat = 1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_led"}, int'(led_fpga), 0);
        chk({tag, "_sel"}, int'(ledm_sel), 0);
        chk({tag, "_sck"}, int'(sp_clk), 0);
        chk({tag, "_dat"}, int'(sp_dat), 0);
        chk({tag, "_lat"}, int'(sp_ratch), 0);
    endtask

    initial begin
        int run_len, rst_len;
        int e_led, e_sel, e_sck, e_dat, e_lat;
        int cap, ncap, prev_sck, prev_lat;

        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("reset");

        for (int ep = 0; ep < 6; ep++) begin
            if (ep == 0)      run_len = 8 * F + 60;                        // full row wrap
            else if (ep == 1) run_len = 2 * F + $urandom_range(3, 16 * S); // reset mid-SHIFT
            else if (ep == 2) run_len = $urandom_range(5, 16 * S);         // reset in first shift
            else              run_len = $urandom_range(20, 3 * F);
            rst_len = $urandom_range(1, 4);
            $display("episode %0d run=%0d reset=%0d", ep, run_len, rst_len);

            reset_n = 1'b0;
            cap = 0; ncap = 0; prev_sck = 0; prev_lat = 0;
            for (int t = 1; t <= run_len; t++) begin
                @(posedge clk);
                #1;
                model(t, e_led, e_sel, e_sck, e_dat, e_lat);
                chk("led_fpga", int'(led_fpga), e_led);
                chk("ledm_sel", int'(ledm_sel), e_sel);
                chk("sp_clk",   int'(sp_clk),   e_sck);
                chk("sp_dat",   int'(sp_dat),   e_dat);
                chk("sp_ratch", int'(sp_ratch), e_lat);
                // external shift register behaviour: sample on sp_clk rise
                if (sp_clk && prev_sck == 0) begin
                    cap  = ((cap << 1) | int'(sp_dat)) & 8'hFF;
                    ncap++;
                end
                if (sp_ratch && prev_lat == 0) begin
                    $display("latch t=%0d row=%0d sel=%0d data=%02h exp=%02h bits=%0d",
                             t, (t / F) % 8, ledm_sel, cap, row_byte(t / F), ncap);
                    chk("latch_byte", cap, row_byte(t / F));
                    chk("latch_bits", ncap, 8);
                    chk("latch_sel", int'(ledm_sel), (t / F) % 8);
                    cap  = 0;
                    ncap = 0;
                end
                prev_sck = int'(sp_clk);
                prev_lat = int'(sp_ratch);
            end

            reset_n = 1'b1;
            for (int r = 0; r < rst_len; r++) begin
                @(posedge clk);
                #1;
                check_all_zero("rst_hold");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
